// File: rtl/multicycle_main_control.sv
// Multi-cycle RV32I main control: FETCH/DECODE/EXEC/MEM/WB sequencer with memory handshakes,
// data-memory timeout and retired-instruction counter. Optional illegal-opcode trap: ILLEGAL_TRAP_EN.
module multicycle_main_control #(
    parameter int ALUOP_W      = 3,
    parameter int INSTRET_W    = 32,
    parameter int DMEM_TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [6:0]           opcode,
    input  logic                 imem_ready,
    input  logic                 dmem_ready,
    output logic                 imem_req,
    output logic                 ir_write,
    output logic                 pc_write,
    output logic                 branch,
    output logic                 mux_inp,
    output logic                 memread,
    output logic                 memwrite,
    output logic [1:0]           memtoreg,
    output logic                 alusrc,
    output logic                 reg_write,
    output logic [ALUOP_W-1:0]   aluop,
    output logic                 dmem_err,
    output logic [INSTRET_W-1:0] instret
`ifdef ILLEGAL_TRAP_EN
    ,
    output logic                 illegal_instr
`endif
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam bit TO_EN = (DMEM_TIMEOUT != 0);
    localparam int CNT_W = (DMEM_TIMEOUT > 1) ? $clog2(DMEM_TIMEOUT) : 1;
    // Counter value seen in the last MEM cycle allowed before the access is abandoned.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TO_EN ? DMEM_TIMEOUT - 1 : 0);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [6:0]           r_opcode;
    logic [CNT_W-1:0]     r_wait_cnt;
    logic                 r_dmem_err;
    logic [INSTRET_W-1:0] r_instret;

    logic       w_dec_valid;
    logic       w_dec_branch;
    logic [1:0] w_dec_memtoreg;
    logic       w_dec_alusrc;
    logic       w_dec_reg_write;
    logic [2:0] w_dec_aluop;
    logic       w_dec_mux_inp;
    logic       w_dec_load;
    logic       w_dec_store;
    logic       w_err_set;
    logic       w_timeout;
`ifdef ILLEGAL_TRAP_EN
    logic       w_illegal;
`endif

    // Opcode classification from the opcode latched in DECODE.
    always_comb begin
        w_dec_valid     = 1'b1;
        w_dec_branch    = 1'b0;
        w_dec_memtoreg  = 2'b11;
        w_dec_alusrc    = 1'b0;
        w_dec_reg_write = 1'b0;
        w_dec_aluop     = 3'd0;
        w_dec_mux_inp   = 1'b0;
        w_dec_load      = 1'b0;
        w_dec_store     = 1'b0;
        case (r_opcode)
            OP_R: begin
                w_dec_memtoreg = 2'b00; w_dec_reg_write = 1'b1; w_dec_aluop = 3'd0;
            end
            OP_I: begin
                w_dec_memtoreg = 2'b00; w_dec_alusrc = 1'b1; w_dec_reg_write = 1'b1; w_dec_aluop = 3'd1;
            end
            OP_LOAD: begin
                w_dec_memtoreg = 2'b01; w_dec_alusrc = 1'b1; w_dec_reg_write = 1'b1; w_dec_aluop = 3'd2;
                w_dec_load = 1'b1;
            end
            OP_STORE: begin
                w_dec_memtoreg = 2'b11; w_dec_alusrc = 1'b1; w_dec_aluop = 3'd3;
                w_dec_store = 1'b1;
            end
            OP_BRANCH: begin
                w_dec_branch = 1'b1; w_dec_memtoreg = 2'b00; w_dec_aluop = 3'd4;
            end
            OP_JAL: begin
                w_dec_memtoreg = 2'b10; w_dec_alusrc = 1'b1; w_dec_reg_write = 1'b1; w_dec_aluop = 3'd5;
            end
            OP_JALR: begin
                w_dec_memtoreg = 2'b10; w_dec_alusrc = 1'b1; w_dec_reg_write = 1'b1; w_dec_aluop = 3'd1;
                w_dec_mux_inp = 1'b1;
            end
            OP_LUI: begin
                w_dec_memtoreg = 2'b10; w_dec_alusrc = 1'b1; w_dec_reg_write = 1'b1; w_dec_aluop = 3'd6;
            end
            OP_AUIPC: begin
                w_dec_memtoreg = 2'b10; w_dec_alusrc = 1'b1; w_dec_reg_write = 1'b1; w_dec_aluop = 3'd0;
            end
            default: w_dec_valid = 1'b0;
        endcase
    end

    assign w_timeout = TO_EN && (r_wait_cnt == CNT_LAST);

    always_comb begin
        w_state_next = r_state;
        imem_req     = 1'b0;
        ir_write     = 1'b0;
        pc_write     = 1'b0;
        branch       = 1'b0;
        mux_inp      = 1'b0;
        memread      = 1'b0;
        memwrite     = 1'b0;
        memtoreg     = 2'b11;
        alusrc       = 1'b0;
        reg_write    = 1'b0;
        aluop        = '0;
        w_err_set    = 1'b0;
`ifdef ILLEGAL_TRAP_EN
        w_illegal    = 1'b0;
`endif
        if (r_state == S_EXEC || r_state == S_MEM || r_state == S_WB) begin
            aluop   = ALUOP_W'(w_dec_aluop);
            alusrc  = w_dec_alusrc;
            mux_inp = w_dec_mux_inp;
        end
        case (r_state)
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_write     = 1'b1;
                    w_state_next = S_DECODE;
                end
            end
            S_DECODE: w_state_next = S_EXEC;
            S_EXEC: begin
                if (!w_dec_valid) begin
`ifdef ILLEGAL_TRAP_EN
                    w_illegal    = 1'b1;
                    w_state_next = S_HALT;
`else
                    pc_write     = 1'b1;
                    w_state_next = S_FETCH;
`endif
                end else if (w_dec_branch) begin
                    branch       = 1'b1;
                    pc_write     = 1'b1;
                    w_state_next = S_FETCH;
                end else if (w_dec_load || w_dec_store) begin
                    w_state_next = S_MEM;
                end else begin
                    w_state_next = S_WB;
                end
            end
            S_MEM: begin
                memread  = w_dec_load;
                memwrite = w_dec_store;
                // A ready on the final allowed cycle still completes normally.
                if (dmem_ready) begin
                    if (w_dec_load) begin
                        w_state_next = S_WB;
                    end else begin
                        pc_write     = 1'b1;
                        w_state_next = S_FETCH;
                    end
                end else if (w_timeout) begin
                    w_err_set    = 1'b1;
                    pc_write     = 1'b1;
                    w_state_next = S_FETCH;
                end
            end
            S_WB: begin
                reg_write    = w_dec_reg_write;
                memtoreg     = w_dec_memtoreg;
                pc_write     = 1'b1;
                w_state_next = S_FETCH;
            end
`ifdef ILLEGAL_TRAP_EN
            S_HALT: w_state_next = S_HALT;
`endif
            default: w_state_next = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_FETCH;
            r_opcode   <= 7'd0;
            r_wait_cnt <= '0;
            r_dmem_err <= 1'b0;
            r_instret  <= '0;
        end else begin
            r_state <= w_state_next;
            if (r_state == S_DECODE) begin
                r_opcode <= opcode;
            end
            if (r_state == S_MEM && w_state_next == S_MEM) begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
            end else begin
                r_wait_cnt <= '0;
            end
            if (w_err_set) begin
                r_dmem_err <= 1'b1;
            end
            if (pc_write) begin
                r_instret <= r_instret + 1'b1;
            end
        end
    end

    assign dmem_err = r_dmem_err;
    assign instret  = r_instret;
`ifdef ILLEGAL_TRAP_EN
    assign illegal_instr = w_illegal;
`endif

endmodule

// File: tb/tb_multicycle_main_control.sv
// Scoreboard bench for multicycle_main_control: the driver queues the expected per-instruction
// summary, the monitor accumulates outputs and compares on every pc_write retirement.
module tb_multicycle_main_control;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] opcode;
    logic       imem_ready;
    logic       dmem_ready;
    logic       imem_req, ir_write, pc_write, branch, mux_inp, memread, memwrite;
    logic [1:0] memtoreg;
    logic       alusrc, reg_write;
    logic [2:0] aluop;
    logic       dmem_err;
    logic [3:0] instret;
`ifdef ILLEGAL_TRAP_EN
    logic       illegal_instr;
`endif

    multicycle_main_control #(
        .ALUOP_W(3),
        .INSTRET_W(4),
        .DMEM_TIMEOUT(16)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .opcode(opcode),
        .imem_ready(imem_ready),
        .dmem_ready(dmem_ready),
        .imem_req(imem_req),
        .ir_write(ir_write),
        .pc_write(pc_write),
        .branch(branch),
        .mux_inp(mux_inp),
        .memread(memread),
        .memwrite(memwrite),
        .memtoreg(memtoreg),
        .alusrc(alusrc),
        .reg_write(reg_write),
        .aluop(aluop),
        .dmem_err(dmem_err),
        .instret(instret)
`ifdef ILLEGAL_TRAP_EN
        ,
        .illegal_instr(illegal_instr)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int op;
        int cycles;
        int irw;
        int mrd;
        int mwr;
        int rgw;
        int br;
        int alu;
        int m2r;
        int asrc;
        int mux;
        int iret;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   ret_cnt = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: accumulate per-instruction activity, compare when the DUT retires.
    initial begin
        int   m_cyc, m_irw, m_mrd, m_mwr, m_rgw, m_br;
        exp_t e;
        m_cyc = 0; m_irw = 0; m_mrd = 0; m_mwr = 0; m_rgw = 0; m_br = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_cyc = 0; m_irw = 0; m_mrd = 0; m_mwr = 0; m_rgw = 0; m_br = 0;
            end else begin
                m_cyc++;
                if (ir_write)  m_irw++;
                if (memread)   m_mrd++;
                if (memwrite)  m_mwr++;
                if (reg_write) m_rgw++;
                if (branch)    m_br++;
                if (pc_write) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_retire", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        chk("cycles",   m_cyc,         e.cycles);
                        chk("ir_write", m_irw,         e.irw);
                        chk("memread",  m_mrd,         e.mrd);
                        chk("memwrite", m_mwr,         e.mwr);
                        chk("reg_write", m_rgw,        e.rgw);
                        chk("branch",   m_br,          e.br);
                        chk("aluop",    int'(aluop),   e.alu);
                        chk("memtoreg", int'(memtoreg), e.m2r);
                        chk("alusrc",   int'(alusrc),  e.asrc);
                        chk("mux_inp",  int'(mux_inp), e.mux);
                        chk("instret",  int'(instret), e.iret);
                        $display("txn op=%02h cycles=%0d rd=%0d wr=%0d rw=%0d br=%0d aluop=%0d m2r=%0d instret=%0d",
                                 e.op, m_cyc, m_mrd, m_mwr, m_rgw, m_br, aluop, memtoreg, instret);
                    end
                    m_cyc = 0; m_irw = 0; m_mrd = 0; m_mwr = 0; m_rgw = 0; m_br = 0;
                end
            end
        end
    end

    // Open-loop driver: fetch ready at cycle fw, data ready at MEM cycle ridx (-1 = never).
    task automatic run_cycles(input logic [6:0] op, input int fw, input int ridx, input int cyc);
        opcode = op;
        for (int c = 0; c < cyc; c++) begin
            imem_ready = (c == fw);
            dmem_ready = (ridx >= 0) && (c == fw + 3 + ridx);
            @(posedge clk);
            #1;
        end
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
    endtask

    task automatic issue(input logic [6:0] op, input int fw, input int ridx, input int cyc,
                         input int mrd, input int mwr, input int rgw, input int br,
                         input int alu, input int m2r, input int asrc, input int mux);
        exp_t e;
        e.op = int'(op); e.cycles = cyc; e.irw = 1; e.mrd = mrd; e.mwr = mwr; e.rgw = rgw;
        e.br = br; e.alu = alu; e.m2r = m2r; e.asrc = asrc; e.mux = mux; e.iret = ret_cnt % 16;
        ret_cnt++;
        sb.push_back(e);
        run_cycles(op, fw, ridx, cyc);
    endtask

    initial begin
        rst_n = 1'b0; opcode = 7'd0; imem_ready = 1'b0; dmem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_imem_req",  int'(imem_req),  1);
        chk("rst_memtoreg",  int'(memtoreg),  3);
        chk("rst_pc_write",  int'(pc_write),  0);
        chk("rst_reg_write", int'(reg_write), 0);
        chk("rst_memread",   int'(memread),   0);
        chk("rst_memwrite",  int'(memwrite),  0);
        chk("rst_aluop",     int'(aluop),     0);
        chk("rst_instret",   int'(instret),   0);
        chk("rst_dmem_err",  int'(dmem_err),  0);
        rst_n = 1'b1;

        //    op        fw rdy cyc rd wr rw br alu m2r src mux
        issue(7'h33,    0, -1,  4, 0, 0, 1, 0, 0,  0,  0,  0);
        issue(7'h13,    2, -1,  6, 0, 0, 1, 0, 1,  0,  1,  0);
        issue(7'h03,    0,  2,  7, 3, 0, 1, 0, 2,  1,  1,  0);
        issue(7'h23,    0,  0,  4, 0, 1, 0, 0, 3,  3,  1,  0);
        issue(7'h63,    0, -1,  3, 0, 0, 0, 1, 4,  3,  0,  0);
        issue(7'h6F,    0, -1,  4, 0, 0, 1, 0, 5,  2,  1,  0);
        issue(7'h67,    0, -1,  4, 0, 0, 1, 0, 1,  2,  1,  1);
        issue(7'h37,    0, -1,  4, 0, 0, 1, 0, 6,  2,  1,  0);
        issue(7'h17,    0, -1,  4, 0, 0, 1, 0, 0,  2,  1,  0);
        issue(7'h23,    0, 15, 19, 0,16, 0, 0, 3,  3,  1,  0);
        chk("dmem_err_ready_wins", int'(dmem_err), 0);
        issue(7'h23,    0, -1, 19, 0,16, 0, 0, 3,  3,  1,  0);
        chk("dmem_err_timeout", int'(dmem_err), 1);

`ifdef ILLEGAL_TRAP_EN
        run_cycles(7'h7F, 0, -1, 2);
        chk("illegal_pulse", int'(illegal_instr), 1);
        chk("illegal_no_pc_write", int'(pc_write), 0);
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("halt_imem_req", int'(imem_req), 0);
            chk("halt_illegal_low", int'(illegal_instr), 0);
            chk("halt_instret", int'(instret), 11);
            @(posedge clk);
            #1;
        end
        chk("dmem_err_sticky", int'(dmem_err), 1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        ret_cnt = 0;
`else
        issue(7'h7F,    0, -1,  3, 0, 0, 0, 0, 0,  3,  0,  0);
        chk("nop_instret", int'(instret), 12);
        chk("dmem_err_sticky", int'(dmem_err), 1);
`endif

        while (ret_cnt < 16) begin
            issue(7'h33, 0, -1, 4, 0, 0, 1, 0, 0, 0, 0, 0);
        end
        chk("instret_wrap", int'(instret), 0);

        // Abandon a load part-way through MEM.
        run_cycles(7'h03, 0, -1, 5);
        chk("mid_mem_memread", int'(memread), 1);
        rst_n = 1'b0;
        #1;
        chk("abort_memread",   int'(memread),   0);
        chk("abort_imem_req",  int'(imem_req),  1);
        chk("abort_memtoreg",  int'(memtoreg),  3);
        chk("abort_pc_write",  int'(pc_write),  0);
        chk("abort_reg_write", int'(reg_write), 0);
        chk("abort_dmem_err",  int'(dmem_err),  0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        ret_cnt = 0;
        issue(7'h33, 0, -1, 4, 0, 0, 1, 0, 0, 0, 0, 0);

        run_cycles(7'h33, 0, -1, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_main_control.md
Name: multicycle_main_control

Overview:
- Multi-cycle successor to the single-cycle opcode decoder.
- FSM sequences each RV32I instruction through FETCH/DECODE/EXEC/MEM/WB.
- Waits on instruction- and data-memory ready handshakes, with a parametrised data-memory timeout.
- Counts retired instructions. Sits between the IR/PC registers and the datapath muxes, ALU, register file and memories.

Parameters:
- ALUOP_W, 3, width of aluop output; encodings 0..6 zero-extended to ALUOP_W.
- INSTRET_W, 32, width of retired-instruction counter; wraps modulo 2^INSTRET_W.
- DMEM_TIMEOUT, 16, max cycles in MEM waiting for dmem_ready; 0 disables the timeout.

Ports:
- clk  in  1  clock, all state changes on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- opcode  in  7  instr[6:0] from IR; sampled only in DECODE.
- imem_ready  in  1  instruction word valid this cycle.
- dmem_ready  in  1  data access complete this cycle.
- imem_req  out  1  instruction fetch request.
- ir_write  out  1  load IR.
- pc_write  out  1  update PC (last cycle of an instruction).
- branch  out  1  branch compare enable.
- mux_inp  out  1  JALR target select.
- memread  out  1  data load request.
- memwrite  out  1  data store request.
- memtoreg  out  2  writeback select: 00 ALU, 01 mem, 10 PC+4/imm, 11 none.
- alusrc  out  1  ALU B operand = immediate.
- reg_write  out  1  register-file write enable.
- aluop  out  ALUOP_W  ALU operation class.
- dmem_err  out  1  sticky data-memory timeout flag.
- instret  out  INSTRET_W  retired-instruction count.

Behaviour:
- Reset: rst_n low clears asynchronously.
  - State goes to FETCH; latched opcode clears to 0.
  - instret = 0, dmem_err = 0, wait counter = 0.
  - Control outputs are combinational, so while rst_n is low (state FETCH): imem_req = 1, memtoreg = 11, all other outputs 0.
  - Reset mid-instruction abandons it with no pc_write and no reg_write.
- Decode table, per latched opcode: branch / memtoreg / alusrc / reg_write / aluop / mux_inp:
  - R 0110011: 0/00/0/1/0/0
  - I 0010011: 0/00/1/1/1/0
  - Load 0000011: 0/01/1/1/2/0, memread
  - Store 0100011: 0/11/1/0/3/0, memwrite
  - Branch 1100011: 1/00/0/0/4/0
  - JAL 1101111: 0/10/1/1/5/0
  - JALR 1100111: 0/10/1/1/1/1
  - LUI 0110111: 0/10/1/1/6/0
  - AUIPC 0010111: 0/10/1/1/0/0
  - Any other opcode: illegal.
- State gating:
  - aluop, alusrc and mux_inp are driven from the latched opcode in EXEC, MEM and WB; 0 in FETCH and DECODE.
  - branch is asserted only in EXEC.
  - memread/memwrite are asserted only in MEM and held until dmem_ready.
  - reg_write is asserted only in WB.
  - memtoreg is the table value in WB, 11 in all other states.
- FETCH:
  - imem_req = 1.
  - On imem_ready: ir_write = 1 for that cycle, go to DECODE. Otherwise stay in FETCH.
- DECODE: latch opcode, go to EXEC (1 cycle).
- EXEC, by latched opcode:
  - Branch: pc_write = 1, go to FETCH.
  - Load/Store: go to MEM.
  - Illegal: behaviour per optional feature.
  - All others: go to WB.
- MEM:
  - Wait counter increments each cycle.
  - On dmem_ready: load goes to WB; store asserts pc_write and goes to FETCH.
  - If DMEM_TIMEOUT != 0 and the counter reaches DMEM_TIMEOUT without dmem_ready: set dmem_err, pc_write = 1, no reg_write, go to FETCH.
  - If dmem_ready arrives on the same cycle the counter reaches DMEM_TIMEOUT, ready wins and no error is flagged.
  - Counter clears on MEM exit.
- WB: reg_write = 1, pc_write = 1, go to FETCH.
- Retirement: instret increments on every cycle with pc_write = 1, including timeout aborts. Wraps from all-ones to 0.
- Latency with zero memory wait: branch 3 cycles; ALU/jump/U-type 4; store 4; load 5.

Optional Feature:
- Macro ILLEGAL_TRAP_EN.
- Defined: adds output illegal_instr (1 bit).
  - Illegal opcode in EXEC: illegal_instr pulses 1 cycle.
  - FSM enters HALT. HALT holds all outputs at their reset values except imem_req = 0.
  - Only rst_n exits HALT; instret does not increment.
- Undefined: illegal opcode in EXEC acts as NOP: pc_write = 1, instret increments, go to FETCH, no other controls asserted.

Test Plan:
- Reset, then R-type 0x33 with imem_ready tied 1 -> ir_write in cycle 0; reg_write = 1, memtoreg = 00, pc_write = 1 in cycle 3; instret = 1.
- Load 0x03, dmem_ready after 3 MEM cycles -> memread high exactly 3 cycles, then WB with memtoreg = 01, reg_write = 1; 7 cycles total.
- Store 0x23 with dmem_ready never asserted, DMEM_TIMEOUT = 16 -> memwrite high 16 cycles, then dmem_err = 1 sticky, pc_write pulse, reg_write never 1, next FETCH.
- Branch 0x63 -> branch = 1 and pc_write = 1 in EXEC (cycle 2), aluop = 4, reg_write never asserted.
- Opcode 0x7F with ILLEGAL_TRAP_EN -> illegal_instr pulse, imem_req = 0 thereafter. Without the macro -> pc_write pulse, instret + 1.
- Preload instret = all-ones via 2^INSTRET_W retirements (INSTRET_W = 4, 16 instrs) -> instret = 0. Assert rst_n low mid-MEM -> memread drops immediately, state FETCH.
